// File: rtl/xfer_pkg.sv
// xfer_pkg: shared types and helpers for the register transfer sequencer.
// Holds the FSM state enum and a one-hot index decoder.
package xfer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  // Widest bank/requester count the decoder supports.
  localparam int MAX_ONEHOT = 64;

  // Callers size-cast the result down to their own vector width.
  function automatic logic [MAX_ONEHOT-1:0] onehot(input logic [5:0] idx);
    logic [MAX_ONEHOT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks one of N requesters; round-robin when XFER_RR_EN is
// defined, lowest-index fixed priority otherwise.
// Ports: clk, rst (sync, active-high), req[N], advance (grant taken),
//        gnt_id (winner index), gnt_valid (any request present).
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [W-1:0] gnt_id,
  output logic         gnt_valid
);

`ifdef XFER_RR_EN
  logic [W-1:0] ptr;
  logic [W-1:0] idx;

  // Scan downwards so the last hit is the one nearest to ptr.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_id    = idx;
        gnt_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && gnt_valid) begin
      ptr <= (int'(gnt_id) == N-1) ? '0 : gnt_id + 1'b1;
    end
  end
`else
  logic unused;
  assign unused = ^{clk, rst, advance};

  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      if (req[W'(k)]) begin
        gnt_id    = W'(k);
        gnt_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/reg_transfer_ctrl.sv
// reg_transfer_ctrl: arbitrates src->dst register moves and drives the bus
// mux select and destination write enable. XFER_RR_EN selects round-robin.
// Ports: clk, rst (sync, active-high); req/req_src/req_dst per requester;
//        done (one-hot pulse), err (bad index pulse), bus_sel, reg_en, busy.
module reg_transfer_ctrl
  import xfer_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_REGS = 8,
  localparam int IDX_W    = $clog2(NUM_REGS),
  localparam int ARB_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_src,
  input  logic [NUM_REQ*IDX_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [IDX_W-1:0]         bus_sel,
  output logic [NUM_REGS-1:0]      reg_en,
  output logic                     busy
);

  state_t state;
  state_t state_n;

  logic [ARB_W-1:0] gnt_id;
  logic             gnt_valid;
  logic             advance;

  logic [ARB_W-1:0] win_id;
  logic [IDX_W-1:0] src_q;
  logic [IDX_W-1:0] dst_q;
  logic             err_q;

  logic [IDX_W-1:0] src_in;
  logic [IDX_W-1:0] dst_in;
  logic             bad_in;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .advance   (advance),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  assign src_in = req_src[int'(gnt_id)*IDX_W +: IDX_W];
  assign dst_in = req_dst[int'(gnt_id)*IDX_W +: IDX_W];

  // Only reachable when NUM_REGS is not a power of two.
  assign bad_in = (int'(src_in) >= NUM_REGS) ||
                  (int'(dst_in) >= NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_id <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      err_q  <= 1'b0;
    end else if (advance) begin
      win_id <= gnt_id;
      src_q  <= src_in;
      dst_q  <= dst_in;
      err_q  <= bad_in;
    end
  end

  always_comb begin
    state_n = state;
    advance = 1'b0;
    bus_sel = '0;
    reg_en  = '0;
    done    = '0;
    err     = 1'b0;
    busy    = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (gnt_valid) begin
          advance = 1'b1;
          state_n = RD;
        end
      end
      RD: begin
        bus_sel = src_q;
        state_n = WR;
      end
      WR: begin
        bus_sel = src_q;
        if (!err_q) begin
          reg_en = NUM_REGS'(onehot(6'(dst_q)));
        end
        state_n = DONE;
      end
      DONE: begin
        done    = NUM_REQ'(onehot(6'(win_id)));
        err     = err_q;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// tb_reg_transfer_ctrl: directed + random bench for reg_transfer_ctrl.
// Drives an 8-register and a 6-register instance from the same requesters.
module tb_reg_transfer_ctrl;

  localparam int NQ = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NQ-1:0] req;
  logic [NQ*IW-1:0] req_src;
  logic [NQ*IW-1:0] req_dst;

  logic [NQ-1:0] a_done, b_done;
  logic          a_err, b_err;
  logic          a_busy, b_busy;
  logic [IW-1:0] a_bus, b_bus;
  logic [7:0]    a_en;
  logic [5:0]    b_en;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: cycles elapsed since grant (0 = idle) and the latched move.
  int ph   = 0;
  int win  = 0;
  int msrc = 0;
  int mdst = 0;
  int ptr  = 0;

  bit hold0 = 1'b0;
  bit auto  = 1'b0;
  bit rec   = 1'b0;
  int order[$];

  always #5 clk = ~clk;

  reg_transfer_ctrl #(
    .NUM_REQ  (NQ),
    .NUM_REGS (8)
  ) u_a (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_src (req_src),
    .req_dst (req_dst),
    .done    (a_done),
    .err     (a_err),
    .bus_sel (a_bus),
    .reg_en  (a_en),
    .busy    (a_busy)
  );

  reg_transfer_ctrl #(
    .NUM_REQ  (NQ),
    .NUM_REGS (6)
  ) u_b (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_src (req_src),
    .req_dst (req_dst),
    .done    (b_done),
    .err     (b_err),
    .bus_sel (b_bus),
    .reg_en  (b_en),
    .busy    (b_busy)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef XFER_RR_EN
    for (int k = 0; k < NQ; k++)
      if (req[(ptr + k) % NQ]) return (ptr + k) % NQ;
`else
    for (int k = 0; k < NQ; k++)
      if (req[k]) return k;
`endif
    return 0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      ph  = 0;
      ptr = 0;
    end else if (ph == 0) begin
      if (req != '0) begin
        win  = pick();
        msrc = int'(req_src[win*IW +: IW]);
        mdst = int'(req_dst[win*IW +: IW]);
        ptr  = (win + 1) % NQ;
        ph   = 1;
      end
    end else begin
      ph = (ph + 1) % 4;
    end
  endtask

  task automatic compare();
    logic [31:0] e_bus, e_en8, e_en6, e_done;
    bit bad;
    bad    = (msrc >= 6) || (mdst >= 6);
    e_bus  = (ph == 1 || ph == 2) ? 32'(msrc) : 32'd0;
    e_en8  = (ph == 2) ? (32'd1 << mdst) : 32'd0;
    e_en6  = (ph == 2 && !bad) ? (32'd1 << mdst) : 32'd0;
    e_done = (ph == 3) ? (32'd1 << win) : 32'd0;
    chk("bus_sel8", 32'(a_bus), e_bus);
    chk("reg_en8", 32'(a_en), e_en8);
    chk("done8", 32'(a_done), e_done);
    chk("err8", 32'(a_err), 32'd0);
    chk("busy8", 32'(a_busy), 32'(ph != 0));
    chk("bus_sel6", 32'(b_bus), e_bus);
    chk("reg_en6", 32'(b_en), e_en6);
    chk("done6", 32'(b_done), e_done);
    chk("err6", 32'(b_err), 32'(ph == 3 && bad));
    chk("busy6", 32'(b_busy), 32'(ph != 0));
    chk("onehot_en", 32'($onehot0(a_en) && $onehot0(b_en)), 32'd1);
    chk("onehot_done", 32'($onehot0(a_done) && $onehot0(b_done)), 32'd1);
    chk("en_done_excl", 32'((|a_en && |a_done) || (|b_en && |b_done)), 32'd0);
    chk("err_with_done", 32'((a_err && !(|a_done)) || (b_err && !(|b_done))), 32'd0);
    if (rec)
      for (int i = 0; i < NQ; i++)
        if (a_done[i]) order.push_back(i);
  endtask

  task automatic put(int i, int s, int d);
    req[i] = 1'b1;
    req_src[i*IW +: IW] = IW'(s);
    req_dst[i*IW +: IW] = IW'(d);
  endtask

  task automatic requesters();
    for (int i = 0; i < NQ; i++) begin
      if (req[i] && ph == 3 && win == i && !(hold0 && i == 0))
        req[i] = 1'b0;
      else if (auto && !req[i] && $urandom_range(0, 3) == 0)
        put(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      else if (auto && req[i] && !(ph != 0 && win == i) &&
               $urandom_range(0, 7) == 0)
        put(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    requesters();
  endtask

  task automatic wait_done(int i);
    int t;
    t = 0;
    do begin
      cycle();
      t++;
    end while (!a_done[i] && t < 12);
    chk("done_seen", 32'(a_done[i]), 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    req_src = '0;
    req_dst = '0;
    cycle();
    cycle();
    rst = 1'b0;

    // Single move 3 -> 5.
    put(0, 3, 5);
    wait_done(0);
    repeat (2) cycle();

    // All four requesting at once.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
`ifdef XFER_RR_EN
    hold0 = 1'b0;
`else
    hold0 = 1'b1;
`endif
    for (int i = 0; i < NQ; i++) put(i, i, 7 - i);
    order.delete();
    rec = 1'b1;
    for (int t = 0; t < 60 && order.size() < 4; t++) cycle();
    rec = 1'b0;
    chk("grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef XFER_RR_EN
      chk("grant_order", 32'(i < order.size() ? order[i] : 99), 32'(i));
`else
      chk("grant_order", 32'(i < order.size() ? order[i] : 99), 32'd0);
`endif
    end
    hold0 = 1'b0;
    req   = '0;
    rst   = 1'b1;
    cycle();
    rst = 1'b0;

    // Out-of-range destination on the 6-register bank, then a legal move.
    put(0, 1, 7);
    wait_done(0);
    put(0, 2, 4);
    wait_done(0);

    // Reset during WR; held request is re-granted afterwards.
    put(2, 6, 1);
    for (int t = 0; t < 8 && ph != 2; t++) cycle();
    chk("reached_wr", 32'(ph), 32'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_done(2);

    // Second request arrives mid-transfer.
    put(1, 0, 2);
    cycle();
    put(2, 3, 4);
    wait_done(1);
    wait_done(2);

    // Random traffic with occasional resets.
    auto = 1'b1;
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    auto = 1'b0;
    rst  = 1'b1;
    req  = '0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
